// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode and direction encodings shared by the LED sequencer files.
package led_seq_pkg;
  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/led_sequencer_tick_gen.sv
// tick_gen: prescaler dividing clk by DIV; tick_int flags terminal count, tick is its registered pulse.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_int,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign tick_int = (r_cnt == W'(DIV - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= en & tick_int;
      if (en) r_cnt <= tick_int ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: moving-light position generator (hold/up/down/bounce) driven by prescaler ticks and manual steps.
// Define LED_SEQUENCER_STEP_SYNC_EN to synchronize step and advance once per rising edge.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int         DIV   = 50_000_000,
  parameter logic [2:0] START = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       step,
  output logic [2:0] state,
  output logic       dir,
  output logic       tick,
  output logic       wrap
);
  logic w_tick_int, w_step_pulse, w_adv, w_turn;
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk(clk), .reset(reset), .en(run), .tick_int(w_tick_int), .tick(tick)
  );
`ifdef LED_SEQUENCER_STEP_SYNC_EN
  logic r_s1, r_s2, r_s3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {r_s1, r_s2, r_s3} <= 3'b000;
    else {r_s1, r_s2, r_s3} <= {step, r_s1, r_s2};
  assign w_step_pulse = r_s2 & ~r_s3;
`else
  assign w_step_pulse = step;
`endif
  assign w_adv  = (run & w_tick_int) | w_step_pulse;
  // Bounce reverses at the end of travel before moving.
  assign w_turn = (dir == DIR_UP) ? (state == 3'd7) : (state == 3'd0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= START;
      dir   <= DIR_UP;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (w_adv)
        case (mode)
          MODE_UP: begin
            state <= state + 3'd1;
            dir   <= DIR_UP;
            wrap  <= (state == 3'd7);
          end
          MODE_DOWN: begin
            state <= state - 3'd1;
            dir   <= DIR_DOWN;
            wrap  <= (state == 3'd0);
          end
          MODE_BOUNCE: begin
            state <= ((dir == DIR_UP) ^ w_turn) ? state + 3'd1 : state - 3'd1;
            dir   <= w_turn ? ~dir : dir;
            wrap  <= w_turn;
          end
          default: ;
        endcase
    end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Generates the 3-bit `state` that drives the 3-to-8 LED decoder, producing a one-hot moving-light display.
- Contains a prescaler that divides the board clock into step ticks.
- A mode-controlled FSM advances `state` up, down, ping-pong or holds it, and accepts a manual single-step input.
- Sits between the top-level switches/buttons and the decoder.

Parameters:
- DIV, 50_000_000: clock cycles per automatic step; legal range ≥1.
- START, 3'd0: `state` value loaded at reset.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- run  input  1  1 = prescaler counts and ticks advance `state`; 0 = prescaler frozen.
- mode  input  2  sequencing mode; encodings in Behaviour.
- step  input  1  manual advance request; one advance per cycle it is high, or per rising edge when STEP_SYNC_EN is defined.
- state  output  3  registered position fed to the decoder.
- dir  output  1  registered direction; 0 = up, 1 = down.
- tick  output  1  registered one-cycle prescaler pulse.
- wrap  output  1  registered one-cycle pulse on end-of-travel.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=START, dir=0, tick=0, wrap=0.
  - Prescaler count=0; step synchronizer flops (if present) = 0.
- Prescaler:
  - Count width is $clog2(DIV), minimum 1.
  - When run=1: count increments each cycle. At count==DIV-1, count returns to 0 and tick=1 the next cycle. Otherwise tick=0.
  - When run=0: count holds and tick=0.
  - DIV=1 gives tick=1 every cycle while run=1.
- Advance condition: adv = (run & tick_int) | step_pulse.
  - tick_int is the combinational terminal-count detect.
  - Simultaneous tick and step produce exactly one advance.
- On adv, `state`, `dir` and `wrap` update on the next clock edge, i.e. latency 1 cycle from adv.
- Mode 2'b00 HOLD:
  - state and dir unchanged; wrap=0.
  - The prescaler still runs.
- Mode 2'b01 UP:
  - state <= state+1, modulo 8; dir <= 0.
  - wrap=1 when the transition is 7→0.
- Mode 2'b10 DOWN:
  - state <= state-1, modulo 8; dir <= 1.
  - wrap=1 when the transition is 0→7.
- Mode 2'b11 BOUNCE: moves in the direction given by dir.
  - dir=0 and state==7: state<=6, dir<=1, wrap=1.
  - dir=1 and state==0: state<=1, dir<=0, wrap=1.
  - Otherwise: state<=state+1 when dir=0, state<=state-1 when dir=1; wrap=0.
- wrap is 0 in every cycle without adv.
- A mode change takes effect at the next adv. The current state is kept; no jump occurs.
- Entering BOUNCE continues in the current dir.
- Reset mid-sequence returns to START immediately, regardless of clk.

Optional Feature:
- Macro: LED_SEQUENCER_STEP_SYNC_EN.
- Defined:
  - `step` passes through a two-flop synchronizer, then a rising-edge detector.
  - step_pulse is one cycle per 0→1 transition of the synchronized signal.
  - The first advance occurs 3 cycles after step rises.
  - Holding step high gives only one advance.
- Undefined:
  - step_pulse = step, used directly.
  - The caller guarantees a synchronous single-cycle pulse; a held step advances every cycle.

Decomposition:
- Package led_seq_pkg:
  - Mode localparams MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_BOUNCE=2'b11.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
- One sub-module, tick_gen:
  - Parameter DIV.
  - Ports clk, reset, en, tick_int (combinational), tick (registered).
  - Prescaler only.
- The FSM and step conditioning stay in led_sequencer.

Test Plan:
- Reset check: DIV=4, START=0; assert reset low mid-run → state=0, dir=0, tick=0, wrap=0 asynchronously, without a clock edge.
- UP wrap: DIV=4, run=1, mode=01 → tick every 4th cycle; state 0,1,…,7,0; wrap=1 exactly on the cycle state shows 0 after 7.
- DOWN: DIV=1, mode=10 from state 2 → state 1,0,7,6 on consecutive cycles; dir=1; wrap on the 0→7 transition only.
- BOUNCE: DIV=1, mode=11 from reset → state 0..7,6..0,1; dir flips to 1 when leaving 7; wrap pulses at the 7→6 and 0→1 reversals.
- HOLD/step collision: run=1, mode=00 → state frozen while tick still pulses. Then mode=01, run=0, step high 1 cycle → exactly one advance 1 cycle later. Then step coincident with tick and run=1 → single advance.
- STEP_SYNC_EN defined: run=0, mode=01, step held high 10 cycles → state +1 once, 3 cycles after the step rise; no further advance until step falls and rises again.
